// File: rtl/qspi_rom_responder.sv
// Quad-SPI flash emulator answering Fast Read Quad I/O (0xEB) from a
// synchronous byte-wide cartridge memory. All SPI pins are oversampled in
// the system clock domain, so clk must run at least four times SCK.
module qspi_rom_responder #(
  parameter int ADDR_BITS     = 24,
  parameter int MEM_ADDR_BITS = 12,
  parameter int DUMMY_CYCLES  = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_select,
  input  logic                     spi_clk_in,
  input  logic [3:0]               spi_data_in,
  output logic [3:0]               spi_data_out,
  output logic [3:0]               spi_data_oe,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_req,
  input  logic [7:0]               mem_data,
  input  logic                     mem_valid,
  output logic                     cmd_error,
  output logic                     underrun
);

  localparam int ADDR_NIBS = ADDR_BITS / 4;
  localparam logic [MEM_ADDR_BITS-1:0] MEM_ONE = 1;

  typedef enum logic [2:0] {IDLE, CMD, IGNORE, ADDR, MODE, DUMMY, DATA} state_t;

  logic [SYNC_STAGES-1:0]      r_sckSync;
  logic [SYNC_STAGES-1:0]      r_selSync;
  logic [SYNC_STAGES-1:0][3:0] r_dinSync;
  logic                        r_sckPrev;

  state_t                   r_state;
  logic [7:0]               r_cnt;
  logic [6:0]               r_shift;
  logic [MEM_ADDR_BITS-5:0] r_addr;
  logic [MEM_ADDR_BITS-1:0] r_memAddr;
  logic [MEM_ADDR_BITS-1:0] r_nextAddr;
  logic                     r_memReq;
  logic                     r_reqPending;
  logic                     r_reqWanted;
  logic                     r_discard;
  logic [7:0]               r_buf;
  logic                     r_bufValid;
  logic [3:0]               r_lowNib;
  logic                     r_phaseLow;
  logic [3:0]               r_dout;
  logic [3:0]               r_oe;
  logic                     r_cmdError;
  logic                     r_underrun;

  logic                     w_sck;
  logic                     w_sel;
  logic [3:0]               w_din;
  logic                     w_sckRise;
  logic                     w_sckFall;
  logic [7:0]               w_cmdNext;
  logic [MEM_ADDR_BITS-1:0] w_addrNext;
  logic                     w_resp;
  logic                     w_issue;

  assign w_sck      = r_sckSync[SYNC_STAGES-1];
  assign w_sel      = r_selSync[SYNC_STAGES-1];
  assign w_din      = r_dinSync[SYNC_STAGES-1];
  assign w_sckRise  = w_sck & ~r_sckPrev;
  assign w_sckFall  = ~w_sck & r_sckPrev;
  // High SPI address bits above the memory width simply shift out the top.
  assign w_cmdNext  = {r_shift, w_din[0]};
  assign w_addrNext = {r_addr, w_din};
  assign w_resp     = mem_valid & r_reqPending;
  assign w_issue    = r_reqWanted & ~r_reqPending;

  assign spi_data_out = r_dout;
  assign spi_data_oe  = r_oe & ~{4{w_sel}};
  assign mem_addr     = r_memAddr;
  assign mem_req      = r_memReq;
  assign cmd_error    = r_cmdError;
  assign underrun     = r_underrun;

  // Bring SCK, select and data lines into the clk domain and keep the
  // previous SCK level for edge detection; select idles deasserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sckSync <= '0;
      r_selSync <= '1;
      r_dinSync <= '0;
      r_sckPrev <= 1'b0;
    end else begin
      r_sckSync[0] <= spi_clk_in;
      r_selSync[0] <= spi_select;
      r_dinSync[0] <= spi_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sckSync[i] <= r_sckSync[i-1];
        r_selSync[i] <= r_selSync[i-1];
        r_dinSync[i] <= r_dinSync[i-1];
      end
      r_sckPrev <= w_sck;
    end
  end

  // Protocol FSM, one-deep read request tracking and the byte buffer that
  // feeds nibbles out on SCK falling edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_memAddr    <= '0;
      r_nextAddr   <= '0;
      r_memReq     <= 1'b0;
      r_reqPending <= 1'b0;
      r_reqWanted  <= 1'b0;
      r_discard    <= 1'b0;
      r_buf        <= '0;
      r_bufValid   <= 1'b0;
      r_lowNib     <= '0;
      r_phaseLow   <= 1'b0;
      r_dout       <= '0;
      r_oe         <= '0;
      r_cmdError   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_memReq   <= 1'b0;
      r_cmdError <= 1'b0;
      if (w_sel) begin
        r_state      <= IDLE;
        r_cnt        <= '0;
        r_shift      <= '0;
        r_addr       <= '0;
        r_reqPending <= 1'b0;
        r_reqWanted  <= 1'b0;
        r_discard    <= 1'b0;
        r_bufValid   <= 1'b0;
        r_phaseLow   <= 1'b0;
        r_dout       <= '0;
        r_oe         <= '0;
      end else begin
        if (w_resp) begin
          r_reqPending <= 1'b0;
          if (r_discard) begin
            r_discard <= 1'b0;
          end else begin
            r_buf      <= mem_data;
            r_bufValid <= 1'b1;
          end
        end else if (w_issue) begin
          r_memReq     <= 1'b1;
          r_reqPending <= 1'b1;
          r_reqWanted  <= 1'b0;
          r_memAddr    <= r_nextAddr;
          r_nextAddr   <= r_nextAddr + MEM_ONE;
        end

        unique case (r_state)
          IDLE: begin
            r_state <= CMD;
            r_cnt   <= '0;
          end
          CMD: if (w_sckRise) begin
            r_shift <= w_cmdNext[6:0];
            r_cnt   <= r_cnt + 8'd1;
            if (r_cnt == 8'd7) begin
              r_cnt <= '0;
              if (w_cmdNext == 8'hEB) begin
                r_state <= ADDR;
              end else begin
                r_cmdError <= 1'b1;
                r_state    <= IGNORE;
              end
            end
          end
          IGNORE: r_state <= IGNORE;
          ADDR: if (w_sckRise) begin
            r_addr <= w_addrNext[MEM_ADDR_BITS-5:0];
            r_cnt  <= r_cnt + 8'd1;
            if (r_cnt == 8'(ADDR_NIBS - 1)) begin
              r_cnt        <= '0;
              r_memAddr    <= w_addrNext;
              r_nextAddr   <= w_addrNext + MEM_ONE;
              r_memReq     <= 1'b1;
              r_reqPending <= 1'b1;
              r_state      <= MODE;
            end
          end
          MODE: if (w_sckRise) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == 8'd1) begin
              r_cnt   <= '0;
              r_state <= DUMMY;
            end
          end
          DUMMY: if (w_sckRise) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == 8'(DUMMY_CYCLES - 1)) begin
              r_cnt      <= '0;
              r_phaseLow <= 1'b0;
              r_state    <= DATA;
            end
          end
          DATA: if (w_sckFall) begin
            r_oe <= 4'hF;
            if (!r_phaseLow) begin
              r_phaseLow  <= 1'b1;
              r_reqWanted <= 1'b1;
              if (r_bufValid) begin
                r_dout     <= r_buf[7:4];
                r_lowNib   <= r_buf[3:0];
                r_bufValid <= 1'b0;
              end else begin
                // Starved byte: send all-ones and make sure its late data
                // is never mistaken for the following byte.
                r_dout     <= 4'hF;
                r_lowNib   <= 4'hF;
                r_underrun <= 1'b1;
                r_bufValid <= 1'b0;
                if (w_issue) begin
                  r_discard <= 1'b1;
                end else if (r_reqWanted) begin
                  r_nextAddr <= r_nextAddr + MEM_ONE;
                end else if (r_reqPending && !mem_valid) begin
                  r_discard <= 1'b1;
                end
              end
            end else begin
              r_phaseLow <= 1'b0;
              r_dout     <= r_lowNib;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_rom_responder.sv
// Scoreboard bench for qspi_rom_responder: a QSPI master model issues
// transactions, a latency-programmable memory model answers reads, and
// monitors compare sampled nibbles and request addresses against queues.
module tb_qspi_rom_responder;

  typedef struct packed {
    logic [3:0] oe;
    logic [3:0] nib;
    logic       chkData;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_select;
  logic        spi_clk_in;
  logic [3:0]  spi_data_in;
  logic [3:0]  spi_data_out;
  logic [3:0]  spi_data_oe;
  logic [11:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic        cmd_error;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int cmdErrCount = 0;
  int nibIdx = 0;
  int sckHalf = 4;
  int memLatency = 2;
  logic sampleNow = 1'b0;

  exp_t        expNib[$];
  logic [11:0] expAddr[$];
  logic [7:0]  mem [4096];

  logic        memBusy = 1'b0;
  int          memCnt = 0;
  logic [11:0] memReqAddr = '0;

  qspi_rom_responder dut (
    .clk          (clk),
    .reset        (reset),
    .spi_select   (spi_select),
    .spi_clk_in   (spi_clk_in),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_data_oe  (spi_data_oe),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_data     (mem_data),
    .mem_valid    (mem_valid),
    .cmd_error    (cmd_error),
    .underrun     (underrun)
  );

  // System clock
  initial forever #5 clk = ~clk;

  // Hard stop in case something stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory model: one outstanding read, answered memLatency clocks later
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (mem_req === 1'b1) begin
      if (memBusy) begin
        checks++;
        errors++;
        $display("[TB] FAIL reqOverlap: got new mem_req at 0x%0h, expected none while 0x%0h outstanding",
                 mem_addr, memReqAddr);
      end
      memBusy    = 1'b1;
      memCnt     = memLatency;
      memReqAddr = mem_addr;
    end
    if (memBusy) begin
      memCnt--;
      if (memCnt == 0) begin
        mem_valid = 1'b1;
        mem_data  = mem[memReqAddr];
        memBusy   = 1'b0;
      end
    end
  end

  // Request monitor: every mem_req pops the next expected address
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      checks++;
      if (expAddr.size() == 0) begin
        errors++;
        $display("[TB] FAIL memAddr: got unexpected request 0x%0h, expected no request", mem_addr);
      end else begin
        logic [11:0] e;
        e = expAddr.pop_front();
        if (mem_addr !== e) begin
          errors++;
          $display("[TB] FAIL memAddr: got 0x%0h, expected 0x%0h", mem_addr, e);
        end
      end
    end
    if (cmd_error === 1'b1) cmdErrCount++;
  end

  // Data monitor: compares the lines whenever the master samples them
  always @(posedge clk) begin
    if (sampleNow) begin
      #1;
      checks++;
      if (expNib.size() == 0) begin
        errors++;
        $display("[TB] FAIL nibble[%0d]: got oe=%h data=%h, expected no sample", nibIdx, spi_data_oe, spi_data_out);
      end else begin
        exp_t e;
        e = expNib.pop_front();
        if (spi_data_oe !== e.oe || (e.chkData && spi_data_out !== e.nib)) begin
          errors++;
          $display("[TB] FAIL nibble[%0d]: got oe=%h data=%h, expected oe=%h data=%h",
                   nibIdx, spi_data_oe, spi_data_out, e.oe, e.nib);
        end
      end
      nibIdx++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushNib(input logic [3:0] oe, input logic [3:0] nib, input logic chk);
    exp_t e;
    e.oe      = oe;
    e.nib     = nib;
    e.chkData = chk;
    expNib.push_back(e);
  endtask

  task automatic pushByte(input logic [7:0] b);
    pushNib(4'hF, b[7:4], 1'b1);
    pushNib(4'hF, b[3:0], 1'b1);
  endtask

  // One SCK period: drive data, rise, optionally sample, optionally fall
  task automatic spiCycle(input logic [3:0] d, input logic smp, input logic fallAfter);
    spi_data_in = d;
    repeat (sckHalf) @(negedge clk);
    spi_clk_in = 1'b1;
    repeat (sckHalf - 1) @(negedge clk);
    sampleNow = smp;
    @(negedge clk);
    sampleNow = 1'b0;
    if (fallAfter) spi_clk_in = 1'b0;
  endtask

  // Full or truncated transaction; mode/dummy only follow a complete address
  task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr, input int nAddr,
                               input int nData, input logic smp, input logic hold);
    int total;
    int k;
    total = 8 + nAddr + ((nAddr == 6) ? 6 : 0) + nData;
    k = 0;
    spi_select = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      k++;
      spiCycle({3'b000, cmd[7-i]}, 1'b0, k < total);
    end
    for (int i = 0; i < nAddr; i++) begin
      k++;
      spiCycle(addr[23-4*i -: 4], 1'b0, k < total);
    end
    if (nAddr == 6) begin
      k++;
      spiCycle(4'hA, 1'b0, k < total);
      k++;
      spiCycle(4'h0, 1'b0, k < total);
      for (int i = 0; i < 4; i++) begin
        k++;
        spiCycle(4'h0, 1'b0, k < total);
      end
    end
    for (int i = 0; i < nData; i++) begin
      k++;
      spiCycle(4'h0, smp, k < total);
    end
    if (!hold) begin
      spi_select = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk_in = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic checkQueues(input string name);
    checkOutput({name, "_nibQueue"}, expNib.size(), 0);
    checkOutput({name, "_addrQueue"}, expAddr.size(), 0);
  endtask

  initial begin
    int errBefore;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h123] = 8'hA5; mem[12'h124] = 8'h3C; mem[12'h125] = 8'h77;
    mem[12'hFFF] = 8'h5A; mem[12'h000] = 8'hE1; mem[12'h001] = 8'h0F;
    mem[12'h010] = 8'h96; mem[12'h011] = 8'h11;
    mem[12'h020] = 8'h4B; mem[12'h021] = 8'hD2; mem[12'h022] = 8'h88; mem[12'h023] = 8'h33;

    reset = 1'b1; spi_select = 1'b1; spi_clk_in = 1'b0; spi_data_in = 4'h0;
    mem_valid = 1'b0; mem_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_oe", spi_data_oe, 4'h0);
    checkOutput("reset_dout", spi_data_out, 4'h0);
    checkOutput("reset_memReq", mem_req, 1'b0);
    checkOutput("reset_memAddr", mem_addr, 12'h000);
    checkOutput("reset_cmdError", cmd_error, 1'b0);
    checkOutput("reset_underrun", underrun, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] basic read from 0x100123");
    expAddr.push_back(12'h123); expAddr.push_back(12'h124); expAddr.push_back(12'h125);
    pushByte(8'hA5); pushByte(8'h3C);
    applyStimulus(8'hEB, 24'h100123, 6, 4, 1'b1, 1'b0);
    checkQueues("basic");
    checkOutput("basic_cmdErrors", cmdErrCount, 0);

    $display("[TB] address wrap at 0xFFF");
    expAddr.push_back(12'hFFF); expAddr.push_back(12'h000); expAddr.push_back(12'h001);
    pushByte(8'h5A); pushByte(8'hE1);
    applyStimulus(8'hEB, 24'h000FFF, 6, 4, 1'b1, 1'b0);
    checkQueues("wrap");

    $display("[TB] unsupported command 0x03");
    errBefore = cmdErrCount;
    for (int i = 0; i < 4; i++) pushNib(4'h0, 4'h0, 1'b0);
    applyStimulus(8'h03, 24'h000000, 0, 4, 1'b1, 1'b0);
    checkOutput("badCmd_pulses", cmdErrCount - errBefore, 1);
    expAddr.push_back(12'h124); expAddr.push_back(12'h125);
    pushByte(8'h3C);
    applyStimulus(8'hEB, 24'h000124, 6, 2, 1'b1, 1'b0);
    checkOutput("afterBadCmd_pulses", cmdErrCount - errBefore, 1);
    checkQueues("badCmd");

    $display("[TB] abort during address then read 0x000010");
    applyStimulus(8'hEB, 24'hFFF000, 3, 0, 1'b0, 1'b0);
    expAddr.push_back(12'h010); expAddr.push_back(12'h011);
    pushByte(8'h96);
    applyStimulus(8'hEB, 24'h000010, 6, 2, 1'b1, 1'b0);
    checkQueues("abort");
    checkOutput("noUnderrunYet", underrun, 1'b0);

    $display("[TB] slow memory, SCK = clk/4");
    sckHalf = 2; memLatency = 8;
    expAddr.push_back(12'h020); expAddr.push_back(12'h021);
    expAddr.push_back(12'h022); expAddr.push_back(12'h023);
    pushByte(8'h4B); pushByte(8'hFF); pushByte(8'hFF);
    applyStimulus(8'hEB, 24'h000020, 6, 6, 1'b1, 1'b0);
    checkQueues("slowMem");
    checkOutput("underrunSet", underrun, 1'b1);

    sckHalf = 4; memLatency = 2;
    expAddr.push_back(12'h123); expAddr.push_back(12'h124);
    pushByte(8'hA5);
    applyStimulus(8'hEB, 24'h000123, 6, 2, 1'b1, 1'b0);
    checkQueues("afterUnderrun");
    checkOutput("underrunSticky", underrun, 1'b1);

    $display("[TB] asynchronous reset during data phase");
    expAddr.push_back(12'h123); expAddr.push_back(12'h124);
    applyStimulus(8'hEB, 24'h000123, 6, 2, 1'b0, 1'b1);
    checkOutput("preReset_oe", spi_data_oe, 4'hF);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncReset_oe", spi_data_oe, 4'h0);
    checkOutput("asyncReset_memReq", mem_req, 1'b0);
    repeat (3) @(negedge clk);
    spi_select = 1'b1;
    spi_clk_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("postReset_oe", spi_data_oe, 4'h0);
    checkOutput("postReset_memAddr", mem_addr, 12'h000);
    checkOutput("postReset_underrun", underrun, 1'b0);
    expAddr.push_back(12'h010); expAddr.push_back(12'h011);
    pushByte(8'h96);
    applyStimulus(8'hEB, 24'h000010, 6, 2, 1'b1, 1'b0);
    checkQueues("postReset");

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
